// File: rtl/crypto_ctrl_pkg.sv
// Shared types and display helpers for the crypto run controller.
package crypto_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan8.sv
// Eight-digit multiplexed seven-segment scanner; the scan counter free-runs,
// enable only gates whether the digits are lit.
module seg_scan8
    import crypto_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        enable,
    output logic [6:0]  Seg,
    output logic [7:0]  An
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       nibble;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        nibble = value[4*idx_q +: 4];
        Seg    = SEG_BLANK;
        An     = 8'hFF;
        if (enable) begin
            Seg = hex_to_seg(nibble);
            An  = ~(8'b1 << idx_q);
        end
    end

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Run controller: load operand, start the core, wait for result or timeout,
// compare against golden, flag TAG. Optional rerun: RERUN_ON_SW_CHANGE_EN.
module crypto_seq_ctrl
    import crypto_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int RESULT_W    = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   SW,
    input  logic [RESULT_W-1:0] core_result,
    input  logic                core_done,
    input  logic [RESULT_W-1:0] golden,
    output logic                core_start,
    output logic [DATA_W-1:0]   core_data,
    output logic                done,
    output logic                TAG,
    output logic [6:0]          Seg,
    output logic [7:0]          An
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   core_data_q;
    logic [RESULT_W-1:0] result_q;
    logic [TMR_W-1:0]    timer_q;
    logic                timeout_q;
    logic                tag_pend_q;
    logic                done_q;
    logic                tag_q;
    logic                rerun;

`ifdef RERUN_ON_SW_CHANGE_EN
    assign rerun = (state_q == DONE) && (SW != core_data_q);
`else
    assign rerun = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = LOAD;
            LOAD:  state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (core_done || (timer_q == TMR_LAST)) state_d = CHECK;
            end
            CHECK: state_d = DONE;
            DONE:  state_d = rerun ? LOAD : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state_q == START);
    end

    // Datapath registers; core_done outranks the timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_data_q <= '0;
            result_q    <= '0;
            timer_q     <= '0;
            timeout_q   <= 1'b0;
            tag_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD:  core_data_q <= SW;
                START: begin
                    timer_q   <= '0;
                    timeout_q <= 1'b0;
                end
                WAIT: begin
                    if (core_done) begin
                        result_q <= core_result;
                    end else if (timer_q == TMR_LAST) begin
                        result_q  <= '1;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                CHECK: tag_pend_q <= timeout_q | (result_q != golden);
                default: ;
            endcase
        end
    end

    // done/TAG are registered while sitting in DONE, so they appear one edge
    // after DONE is entered and drop on the same edge a rerun leaves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            tag_q  <= 1'b0;
        end else if (state_q == DONE && !rerun) begin
            done_q <= 1'b1;
            tag_q  <= tag_pend_q;
        end else begin
            done_q <= 1'b0;
            tag_q  <= 1'b0;
        end
    end

    assign core_data = core_data_q;
    assign done      = done_q;
    assign TAG       = tag_q;

    seg_scan8 #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .value  (result_q[31:0]),
        .enable (done_q),
        .Seg    (Seg),
        .An     (An)
    );

endmodule
